// File: rtl/alu_seq.sv
// Execute-stage ALU: single-cycle base ops plus iterative unsigned MUL/DIVU/REMU.
// Latency: 1 cycle for base ops; XLEN+1 cycles for mul/divu/remu (one bit per cycle).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module alu_seq #(
    parameter int XLEN      = 32,
    parameter int SHAMT_W   = $clog2(XLEN),
    parameter int LUI_SHIFT = 12
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] alu_in1,
    input  logic [XLEN-1:0] alu_in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            out_zero,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SRA  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_NE   = 4'b0111;
    localparam logic [3:0] OP_LUI  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [3:0]         op_q;
    // MUL: opa_q = shifting multiplicand, opb_q = shifting multiplier, acc_q = product.
    // DIV: opa_q = dividend shifting out / quotient shifting in, opb_q = divisor,
    //      acc_q = partial remainder.
    logic [XLEN-1:0]    opa_q;
    logic [XLEN-1:0]    opb_q;
    logic [XLEN-1:0]    acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [XLEN-1:0]    simple_res;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    mul_acc_nxt;
    logic [XLEN:0]      div_rsh;
    logic [XLEN:0]      div_diff;
    logic               div_ok;
    logic [XLEN-1:0]    div_rem_nxt;
    logic [XLEN-1:0]    div_quo_nxt;
    logic               last_iter;

    assign shamt     = alu_in2[SHAMT_W-1:0];
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    // Single-cycle result for every non-iterative opcode; unused codes fall back to add.
    always_comb begin
        simple_res = alu_in1 + alu_in2;
        case (alu_sel)
            OP_ADD:  simple_res = alu_in1 + alu_in2;
            OP_SUB:  simple_res = alu_in1 - alu_in2;
            OP_AND:  simple_res = alu_in1 & alu_in2;
            OP_XOR:  simple_res = alu_in1 ^ alu_in2;
            OP_SRA:  simple_res = $unsigned($signed(alu_in1) >>> shamt);
            OP_SLL:  simple_res = alu_in1 << shamt;
            OP_SRL:  simple_res = alu_in1 >> shamt;
            OP_NE:   simple_res = {{(XLEN-1){1'b0}}, (alu_in1 != alu_in2)};
            OP_LUI:  simple_res = alu_in2 << LUI_SHIFT;
            default: simple_res = alu_in1 + alu_in2;
        endcase
    end

    // One shift-add multiply step and one restoring-divide step from the current state.
    // A zero divisor never borrows, so the quotient fills with ones and the
    // remainder ends up equal to the dividend without any special casing.
    always_comb begin
        mul_acc_nxt = opb_q[0] ? (acc_q + opa_q) : acc_q;
        div_rsh     = {acc_q, opa_q[XLEN-1]};
        div_diff    = div_rsh - {1'b0, opb_q};
        div_ok      = ~div_diff[XLEN];
        div_rem_nxt = div_ok ? div_diff[XLEN-1:0] : div_rsh[XLEN-1:0];
        div_quo_nxt = {opa_q[XLEN-2:0], div_ok};
    end

    // Control FSM and datapath registers; the final iteration writes alu_out directly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            alu_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q  <= alu_sel;
                        opa_q <= alu_in1;
                        opb_q <= alu_in2;
                        acc_q <= '0;
                        cnt_q <= '0;
                        case (alu_sel)
                            OP_MUL:           state <= S_MUL;
                            OP_DIVU, OP_REMU: state <= S_DIV;
                            default: begin
                                alu_out <= simple_res;
                                state   <= S_DONE;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    acc_q <= mul_acc_nxt;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        alu_out <= mul_acc_nxt;
                        state   <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc_q <= div_rem_nxt;
                    opa_q <= div_quo_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        alu_out <= (op_q == OP_REMU) ? div_rem_nxt : div_quo_nxt;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake/status flags decode straight from the state register.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign out_zero  = (alu_out == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases, backpressure, mid-op reset, random ops.
// Checks result, out_zero and issue-to-valid latency against a reference model.
// Drives and samples 1 time unit after the rising clock edge.
module tb_alu_seq;

    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_out;
    logic            out_zero;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    alu_seq #(.XLEN(XLEN), .SHAMT_W(5), .LUI_SHIFT(12)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_sel   (alu_sel),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    task automatic check_dat(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic definitions of each opcode.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] prod;
        int          sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a ^ b;
            4'd4:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return (a != b) ? 32'd1 : 32'd0;
            4'd8:  return b << 12;
            4'd9: begin
                prod = {32'd0, a} * {32'd0, b};
                return prod[31:0];
            end
            4'd10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd11: return (b == 0) ? a : a % b;
            default: return a + b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        return (op == 4'd9 || op == 4'd10 || op == 4'd11) ? XLEN + 1 : 1;
    endfunction

    // Present one op and return once it has been accepted.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clock); #1;
            t++;
        end
        if (!in_ready) check_dat("in_ready_timeout", 32'(in_ready), 32'd1);
        alu_sel  = op;
        alu_in1  = a;
        alu_in2  = b;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accepting edge.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          lat;
        logic [31:0] exp;
        exp = ref_result(op, a, b);
        out_ready = 1'b0;
        send(op, a, b);
        wait_result(lat);
        check_dat({tag, "_lat"}, 32'(lat), 32'(ref_lat(op)));
        check_dat({tag, "_res"}, alu_out, exp);
        check_dat({tag, "_zero"}, 32'(out_zero), (exp == 0) ? 32'd1 : 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check_dat({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            check_dat({tag, "_hold_res"}, alu_out, exp);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check_dat({tag, "_drop"}, 32'(out_valid), 32'd0);
        check_dat({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          pat;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_sel   = '0;
        alu_in1   = '0;
        alu_in2   = '0;
        #12;
        check_dat("rst_out_valid", 32'(out_valid), 32'd0);
        check_dat("rst_in_ready", 32'(in_ready), 32'd1);
        check_dat("rst_alu_out", alu_out, 32'd0);
        check_dat("rst_out_zero", 32'(out_zero), 32'd1);
        check_dat("rst_busy", 32'(busy), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Add wrap and zero flag.
        run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 0);
        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 0);
        // Shifts, shamt from low 5 bits only.
        run_op("sra", 4'd4, 32'h8000_0000, 32'd4, 0);
        run_op("srl", 4'd6, 32'h8000_0000, 32'd4, 0);
        run_op("sll31", 4'd5, 32'd1, 32'd31, 0);
        run_op("sll_shamt", 4'd5, 32'd1, 32'h21, 0);
        run_op("lui", 4'd8, 32'd0, 32'h000A_BCDE, 0);
        run_op("ne_eq", 4'd7, 32'h1234, 32'h1234, 0);
        // Iterative ops.
        run_op("mul", 4'd9, 32'h0001_0001, 32'h0001_0001, 0);
        run_op("mul_max", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("divu", 4'd10, 32'd100, 32'd7, 0);
        run_op("remu", 4'd11, 32'd100, 32'd7, 0);
        run_op("divu_z", 4'd10, 32'hDEAD_BEEF, 32'd0, 0);
        run_op("remu_z", 4'd11, 32'd100, 32'd0, 0);

        // Backpressure: held result, competing in_valid ignored until IDLE.
        send(4'd9, 32'h0001_0001, 32'h0001_0001);
        wait_result(lat);
        check_dat("bp_lat", 32'(lat), 32'(XLEN + 1));
        alu_sel  = 4'd0;
        alu_in1  = 32'd5;
        alu_in2  = 32'd6;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check_dat("bp_vld", 32'(out_valid), 32'd1);
            check_dat("bp_res", alu_out, 32'h0002_0001);
            check_dat("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check_dat("bp_drop", 32'(out_valid), 32'd0);
        check_dat("bp_idle", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        check_dat("bp_second_vld", 32'(out_valid), 32'd1);
        check_dat("bp_second_res", alu_out, 32'd11);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;

        // Reset asserted in cycle 10 of a divide.
        send(4'd10, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clock); #1;
        end
        check_dat("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_dat("mrst_out_valid", 32'(out_valid), 32'd0);
        check_dat("mrst_in_ready", 32'(in_ready), 32'd1);
        check_dat("mrst_alu_out", alu_out, 32'd0);
        check_dat("mrst_out_zero", 32'(out_zero), 32'd1);
        check_dat("mrst_busy", 32'(busy), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (XLEN + 4) begin
            @(posedge clock); #1;
            check_dat("mrst_no_result", 32'(out_valid), 32'd0);
        end
        run_op("post_rst_add", 4'd0, 32'd3, 32'd4, 0);

        // Random ops with operand patterns and random hold times.
        for (int i = 0; i < 120; i++) begin
            op  = 4'($urandom_range(0, 15));
            pat = int'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            case (pat)
                1: begin
                    a = 32'($urandom_range(0, 20));
                    b = 32'($urandom_range(0, 20));
                end
                2: b = 32'd0;
                3: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op("rnd", op, a, b, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
